// File: rtl/rv_dmem_io.sv
// Data-memory and I/O slave for the multicycle RISC-V core: word RAM with
// combinational read, a memory-mapped byte TX FIFO, and a free-running cycle counter.
module rv_dmem_io #(
    parameter int DPWIDTH   = 32,
    parameter int DMEMWORDS = 1024,
    parameter int TXDEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
    input  logic               memrw,
    output logic [DPWIDTH-1:0] dmem_datain,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);
    localparam int RAW = $clog2(DMEMWORDS);
    localparam int AW  = $clog2(TXDEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(TXDEPTH);
    localparam logic [AW:0] LAST_C  = (AW+1)'(TXDEPTH - 1);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [DPWIDTH-1:0] ram_reg [DMEMWORDS];
    logic [TXDEPTH-1:0][7:0] fifo_q;

    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] count_reg, count_next;
    logic        ovf_reg, ovf_next;
    logic [DPWIDTH-1:0] cycle_reg;

    logic sel_tx, sel_status, sel_cycle;
    logic push_req, push_ok, pop;
    logic fifo_full, fifo_empty;
    logic unused_addr_lsb;

    // Byte-offset bits are don't-care: every access is a whole word.
    assign unused_addr_lsb = ^dmem_addr[1:0];

    assign sel_tx     = (dmem_addr[31:2] == 30'h2000_0000);
    assign sel_status = (dmem_addr[31:2] == 30'h2000_0001);
    assign sel_cycle  = (dmem_addr[31:2] == 30'h2000_0002);

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);
    assign pop        = !fifo_empty && tx_ready;
    assign push_req   = memrw && sel_tx;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_q[rd_ptr_reg[AW-1:0]];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + ONE_C;
        end
        if (push_ok) begin
            wr_ptr_next = (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + ONE_C;
        end
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + ONE_C;
            2'b01:   count_next = count_reg - ONE_C;
            default: count_next = count_reg;
        endcase
        if (push_req && !push_ok) begin
            ovf_next = 1'b1;
        end else if (memrw && sel_status && dmem_dataout[2]) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            cycle_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            cycle_reg  <= cycle_reg + DPWIDTH'(1);
        end
    end

    // FIFO byte slots; pointers are cleared by reset so stale contents never surface.
    genvar gi;
    generate
        for (gi = 0; gi < TXDEPTH; gi++) begin : g_fifo
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (!rst && push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    byte_reg <= dmem_dataout[7:0];
                end
            end
            assign fifo_q[gi] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (memrw && !dmem_addr[31]) begin
            ram_reg[dmem_addr[RAW+1:2]] <= dmem_dataout;
        end
    end

    always_comb begin
        dmem_datain = '0;
        if (!dmem_addr[31]) begin
            dmem_datain = ram_reg[dmem_addr[RAW+1:2]];
        end else if (sel_status) begin
            dmem_datain = {{(DPWIDTH-3){1'b0}}, ovf_reg, fifo_full, fifo_empty};
        end else if (sel_cycle) begin
            dmem_datain = cycle_reg;
        end
    end
endmodule

// File: tb/tb_rv_dmem_io.sv
// Directed bench for rv_dmem_io: RAM access/alias, TX FIFO fill/overflow/drain,
// overflow clear, cycle counter and wrap, and reset in mid-drain.
module tb_rv_dmem_io;
    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;

    logic        clk;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dataout;
    logic        memrw;
    logic [31:0] dmem_datain;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_cmp = 0;
    int n_bad = 0;

    rv_dmem_io #(.DPWIDTH(32), .DMEMWORDS(1024), .TXDEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_dataout (dmem_dataout),
        .memrw        (memrw),
        .dmem_datain  (dmem_datain),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-12s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %-12s got=%h", tag, got);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        dmem_addr    = a;
        dmem_dataout = d;
        memrw        = 1'b1;
        @(negedge clk);
        memrw        = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        dmem_addr = a;
        memrw     = 1'b0;
        #1;
        d = dmem_datain;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  exp_q[$];

        rst = 1'b1; tx_ready = 1'b0; memrw = 1'b0;
        dmem_addr = A_STATUS; dmem_dataout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_status", dmem_datain, 32'h1);
        rst = 1'b0;

        // cycle counter after 5 non-reset edges
        repeat (5) @(posedge clk);
        rd(A_CYCLE, r);       check("cycle_n", r, 32'd5);

        // RAM write, word read, ignored byte offset, alias
        wr(32'h40, 32'hDEAD_BEEF);
        rd(32'h40, r);        check("ram_rd", r, 32'hDEAD_BEEF);
        rd(32'h43, r);        check("ram_rd_off", r, 32'hDEAD_BEEF);
        rd(32'h40 + 4*1024, r); check("ram_alias", r, 32'hDEAD_BEEF);
        rd(A_TX, r);          check("txdata_rd", r, 32'h0);
        rd(32'h8000_0010, r); check("unmapped_rd", r, 32'h0);
        wr(A_CYCLE, 32'h1234_5678);
        rd(32'h40, r);        check("ram_after_io", r, 32'hDEAD_BEEF);

        // fill FIFO, then overflow
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h41 + i);
        rd(A_STATUS, r);      check("st_full", r, 32'h2);
        wr(A_TX, 32'h45);
        rd(A_STATUS, r);      check("st_ovf", r, 32'h6);
        check("head_kept", {24'b0, tx_data}, 32'h41);

        // drain
        @(negedge clk); tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("drain_vld", {31'b0, tx_valid}, 32'h1);
            check("drain_dat", {24'b0, tx_data}, 32'h41 + i);
        end
        @(negedge clk); #1;
        check("drained_vld", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd(A_STATUS, r);      check("st_empty_ovf", r, 32'h5);

        // ovf clear only when data[2] set
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, r);      check("ovf_keep", r, 32'h5);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, r);      check("ovf_clear", r, 32'h1);

        // full FIFO + pop + push in the same cycle
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h41 + i);
        exp_q = '{8'h42, 8'h43, 8'h44, 8'h55};
        @(negedge clk);
        tx_ready = 1'b1; dmem_addr = A_TX; dmem_dataout = 32'h55; memrw = 1'b1;
        #1; check("pp_head", {24'b0, tx_data}, 32'h41);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); memrw = 1'b0; #1;
            check("pp_vld", {31'b0, tx_valid}, 32'h1);
            check("pp_dat", {24'b0, tx_data}, {24'b0, exp_q[i]});
        end
        @(negedge clk); #1;
        check("pp_empty", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd(A_STATUS, r);      check("pp_status", r, 32'h1);

        // counter wrap
        @(negedge clk);
        dmem_addr = A_CYCLE;
        force dut.cycle_reg = 32'hFFFF_FFFF;
        #1; check("cycle_max", dmem_datain, 32'hFFFF_FFFF);
        release dut.cycle_reg;
        @(negedge clk); #1;
        check("cycle_wrap", dmem_datain, 32'h0);

        // reset mid-drain, with a push attempted during reset
        wr(A_TX, 32'h61);
        wr(A_TX, 32'h62);
        tx_ready = 1'b1; #1;
        check("rs_head0", {24'b0, tx_data}, 32'h61);
        @(negedge clk); #1;
        check("rs_head1", {24'b0, tx_data}, 32'h62);
        rst = 1'b1; dmem_addr = A_TX; dmem_dataout = 32'h77; memrw = 1'b1;
        @(negedge clk);
        rst = 1'b0; memrw = 1'b0; tx_ready = 1'b0; #1;
        check("rs_valid", {31'b0, tx_valid}, 32'h0);
        dmem_addr = A_STATUS; #1;
        check("rs_status", dmem_datain, 32'h1);
        dmem_addr = A_CYCLE; #1;
        check("rs_cycle", dmem_datain, 32'h0);
        @(negedge clk); #1;
        check("rs_nopush", {31'b0, tx_valid}, 32'h0);
        rd(32'h40, r);        check("rs_ram", r, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
